// File: rtl/loader_pkg.sv
// loader_pkg: shared encodings and LeNet default layout for framed_weight_loader.
//   state_t      : FSM states (IDLE / LOAD / CSUM)
//   err_t        : err_code values (none / checksum / timeout)
//   LOADER_MAGIC : frame start byte
//   LENET_*      : 11-section LeNet layout, section 0 in the least significant slot
package loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CSUM = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_CSUM    = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_t;

    localparam logic [7:0] LOADER_MAGIC = 8'hA5;
    localparam int LENET_NUM_SEC = 11;

    // Sections: conv1 w/b, conv2 w/b, fc1 w/b, fc2 w/b, fc3 w/b, tanh LUT.
    // Weights are int8, biases int32, LUT entries unsigned bytes.
    localparam logic [11*20-1:0] LENET_SEC_LEN = {
        20'd256, 20'd40, 20'd840, 20'd336, 20'd10080, 20'd480,
        20'd48000, 20'd64, 20'd2400, 20'd24, 20'd150
    };
    localparam logic [11*3-1:0] LENET_SEC_EBYTES = {
        3'd1, 3'd4, 3'd1, 3'd4, 3'd1, 3'd4, 3'd1, 3'd4, 3'd1, 3'd4, 3'd1
    };
    // Conv biases share a RAM (0/6), fc biases share another (0/120/204).
    localparam logic [11*16-1:0] LENET_SEC_BASE = {
        16'd0, 16'd204, 16'd58080, 16'd120, 16'd48000, 16'd0,
        16'd0, 16'd6, 16'd150, 16'd0, 16'd0
    };
    localparam logic [10:0] LENET_SEC_SIGNED = 11'b011_1111_1111;

endpackage

// File: rtl/loader_elem_asm.sv
// loader_elem_asm: little-endian byte-lane assembly with sign/zero extension.
//   clk, rst : clock, synchronous active-high reset
//   load     : store byte_in into lane
//   lane     : byte position of byte_in within the element
//   byte_in  : incoming byte
//   sgn      : sign-extend the element from byte_in's msb
//   word     : {byte_in, earlier lanes}, lanes above `lane` filled with the extension
module loader_elem_asm #(
    parameter int MAX_BYTES = 4,
    parameter int LW = $clog2(MAX_BYTES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [LW-1:0]          lane,
    input  logic [7:0]             byte_in,
    input  logic                   sgn,
    output logic [8*MAX_BYTES-1:0] word
);

    logic [7:0] held [MAX_BYTES];

    always_ff @(posedge clk) begin
        if (rst)
            for (int j = 0; j < MAX_BYTES; j++) held[j] <= 8'h00;
        else if (load)
            held[lane] <= byte_in;
    end

    // The element's last byte arrives live, so it is merged combinationally.
    always_comb begin
        word = '0;
        for (int j = 0; j < MAX_BYTES; j++)
            word[j*8 +: 8] = (j == int'(lane)) ? byte_in :
                             (j <  int'(lane)) ? held[j] : {8{sgn & byte_in[7]}};
    end

endmodule

// File: rtl/framed_weight_loader.sv
// framed_weight_loader: framed UART byte stream to a generic element write port.
//   clk, rst          : clock, synchronous active-high reset
//   rx_data, rx_ready : received byte and its one-cycle strobe
//   wr_en             : one-cycle element write strobe (1 cycle after the last byte)
//   wr_sec, wr_addr   : section id and SEC_BASE[sec] + element index
//   wr_data           : assembled, extended element
//   busy              : frame in progress
//   transfer_done     : frame ended with a good checksum (sticky until MAGIC/rst)
//   error, err_code   : checksum or timeout abort (sticky until MAGIC/rst)
//   progress          : payload bytes accepted in the current frame
module framed_weight_loader import loader_pkg::*; #(
    parameter int                    NUM_SEC     = LENET_NUM_SEC,
    parameter logic [NUM_SEC*20-1:0] SEC_LEN     = LENET_SEC_LEN,
    parameter logic [NUM_SEC*3-1:0]  SEC_EBYTES  = LENET_SEC_EBYTES,
    parameter logic [NUM_SEC*16-1:0] SEC_BASE    = LENET_SEC_BASE,
    parameter logic [NUM_SEC-1:0]    SEC_SIGNED  = LENET_SEC_SIGNED,
    parameter logic [7:0]            MAGIC       = LOADER_MAGIC,
    parameter int                    TIMEOUT_CYC = 10_000_000,
    parameter int                    PROG_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              wr_en,
    output logic [3:0]        wr_sec,
    output logic [15:0]       wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              transfer_done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [PROG_W-1:0] progress
);

    state_t      state, state_nx;
    logic [3:0]  sec;
    logic [19:0] byte_in_sec;
    logic [1:0]  byte_idx;
    logic [15:0] elem_idx;
    logic [7:0]  csum;
    logic [31:0] gap;
    logic [31:0] asm_word;

    // Section tables padded to 16 entries so a 4-bit sec indexes them cleanly.
    logic [19:0] len_a  [16];
    logic [2:0]  eb_a   [16];
    logic [15:0] base_a [16];
    logic        sgn_a  [16];

    for (genvar i = 0; i < 16; i++) begin : g_sec
        if (i < NUM_SEC) begin : g_on
            assign len_a[i]  = SEC_LEN[i*20 +: 20];
            assign eb_a[i]   = SEC_EBYTES[i*3 +: 3];
            assign base_a[i] = SEC_BASE[i*16 +: 16];
            assign sgn_a[i]  = SEC_SIGNED[i];
        end else begin : g_off
            assign len_a[i]  = '0;
            assign eb_a[i]   = '0;
            assign base_a[i] = '0;
            assign sgn_a[i]  = 1'b0;
        end
    end

    logic is_magic, elem_last, sec_last, last_sec, timeout, load_byte;

    assign is_magic  = rx_ready && rx_data == MAGIC;
    assign elem_last = {1'b0, byte_idx} == eb_a[sec] - 3'd1;
    assign sec_last  = byte_in_sec == len_a[sec] - 20'd1;
    assign last_sec  = sec == 4'(NUM_SEC - 1);
    assign load_byte = state == S_LOAD && rx_ready;
    // A byte arriving on the final allowed idle cycle still counts.
    assign timeout   = (TIMEOUT_CYC != 0) && !rx_ready && gap == 32'(TIMEOUT_CYC - 1);

    loader_elem_asm #(.MAX_BYTES(4)) u_asm (
        .clk     (clk),
        .rst     (rst),
        .load    (load_byte),
        .lane    (byte_idx),
        .byte_in (rx_data),
        .sgn     (sgn_a[sec]),
        .word    (asm_word)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = is_magic ? S_LOAD : S_IDLE;
            S_LOAD:  state_nx = timeout ? S_IDLE :
                                (rx_ready && sec_last && last_sec) ? S_CSUM : S_LOAD;
            S_CSUM:  state_nx = (timeout || rx_ready) ? S_IDLE : S_CSUM;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb busy = state != S_IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en         <= 1'b0;
            wr_sec        <= '0;
            wr_addr       <= '0;
            wr_data       <= '0;
            transfer_done <= 1'b0;
            error         <= 1'b0;
            err_code      <= ERR_NONE;
            progress      <= '0;
            sec           <= '0;
            byte_in_sec   <= '0;
            byte_idx      <= '0;
            elem_idx      <= '0;
            csum          <= '0;
            gap           <= '0;
        end else begin
            wr_en <= 1'b0;
            if (state == S_IDLE) begin
                if (is_magic) begin
                    transfer_done <= 1'b0;
                    error         <= 1'b0;
                    err_code      <= ERR_NONE;
                    progress      <= '0;
                    sec           <= '0;
                    byte_in_sec   <= '0;
                    byte_idx      <= '0;
                    elem_idx      <= '0;
                    csum          <= '0;
                    gap           <= '0;
                end
            end else if (timeout) begin
                error    <= 1'b1;
                err_code <= ERR_TIMEOUT;
            end else if (rx_ready) begin
                gap <= '0;
                if (state == S_LOAD) begin
                    csum        <= csum + rx_data;
                    progress    <= progress + PROG_W'(1);
                    byte_idx    <= elem_last ? 2'd0 : byte_idx + 2'd1;
                    byte_in_sec <= byte_in_sec + 20'd1;
                    if (elem_last) begin
                        wr_en    <= 1'b1;
                        wr_sec   <= sec;
                        wr_addr  <= base_a[sec] + elem_idx;
                        wr_data  <= asm_word;
                        elem_idx <= elem_idx + 16'd1;
                    end
                    // Section lengths are whole elements, so this coincides with elem_last.
                    if (sec_last) begin
                        sec         <= sec + 4'd1;
                        elem_idx    <= '0;
                        byte_in_sec <= '0;
                    end
                end else if (rx_data == csum) begin
                    transfer_done <= 1'b1;
                end else begin
                    error    <= 1'b1;
                    err_code <= ERR_CSUM;
                end
            end else begin
                gap <= gap + 32'd1;
            end
        end
    end

endmodule
